// File: rtl/jenc_bitstream_packer.sv
// rtl/jenc_bitstream_packer.sv - JPEG entropy bitstream packer: bit concatenation, 0xFF stuffing, pad, EOI, 32-bit words
module jenc_bitstream_packer #(
  parameter int ACC_W      = 128,
  parameter bit APPEND_EOI = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [51:0] in_codecoeff,
  input  logic [5:0]  in_codecoeff_length,
  input  logic        in_tlast,
  input  logic        in_valid,
  output logic        in_hold,
  output logic [31:0] out_data,
  output logic [2:0]  out_bytes,
  output logic        out_tlast,
  output logic        out_valid,
  input  logic        out_hold
);
  localparam int FW  = $clog2(ACC_W + 1);
  localparam int STG = 12;

  typedef enum logic [2:0] {RUN, PAD, DRAIN, EOI, FLUSH} state_t;
  state_t state, state_n;

  logic [ACC_W-1:0] acc, acc_n, acc_pop;
  logic [FW-1:0]    fill, fill_n, fill_pop, fill_up;
  logic [7:0]       stg [STG];
  logic [7:0]       stg_n [STG];
  logic [7:0]       pb [4];
  logic [3:0]       stg_cnt, stg_cnt_n, after, room, idx, src;
  logic [2:0]       nload, k;
  logic [51:0]      chunk_m;
  logic [31:0]      word;
  logic             can_out, ld_ok, load, len_ok, accept, eoi_push;

  always_comb begin
    can_out = !out_valid || !out_hold;
    // Without EOI, keep at least one byte back during DRAIN so FLUSH always has a tlast word.
    if (state == FLUSH)                   ld_ok = stg_cnt != 4'd0;
    else if (!APPEND_EOI && state == DRAIN) ld_ok = stg_cnt > 4'd4;
    else                                  ld_ok = stg_cnt >= 4'd4;
    load  = can_out && ld_ok;
    nload = 3'd0;
    if (load) nload = (stg_cnt < 4'd4) ? stg_cnt[2:0] : 3'd4;
    after = stg_cnt - {1'b0, nload};
    // Each popped byte may expand to two staging bytes.
    room  = (4'(STG) - after) >> 1;
    k = 3'd4;
    if (fill < FW'(32)) k = {1'b0, fill[4:3]};
    if (room < {1'b0, k}) k = room[2:0];

    pb[0] = acc[ACC_W-1  -: 8];
    pb[1] = acc[ACC_W-9  -: 8];
    pb[2] = acc[ACC_W-17 -: 8];
    pb[3] = acc[ACC_W-25 -: 8];

    src = 4'd0;
    for (int i = 0; i < STG; i++) begin
      src = 4'(i) + {1'b0, nload};
      stg_n[i] = (src < 4'(STG)) ? stg[src] : 8'h00;
    end
    idx = after;
    for (int i = 0; i < 4; i++) begin
      if (3'(i) < k) begin
        if (idx < 4'(STG)) stg_n[idx] = pb[i];
        idx = idx + 4'd1;
        if (pb[i] == 8'hFF) begin
          if (idx < 4'(STG)) stg_n[idx] = 8'h00;
          idx = idx + 4'd1;
        end
      end
    end
    eoi_push = (state == EOI) && (after <= 4'(STG - 2));
    if (eoi_push) begin
      stg_n[idx]        = 8'hFF;
      stg_n[idx + 4'd1] = 8'hD9;
      idx = idx + 4'd2;
    end
    stg_cnt_n = idx;

    acc_pop  = acc << {k, 3'b000};
    fill_pop = fill - FW'({k, 3'b000});
    fill_up  = {fill_pop[FW-1:3] + {{(FW-4){1'b0}}, |fill_pop[2:0]}, 3'b000};
    len_ok   = (in_codecoeff_length != 6'd0) && (in_codecoeff_length <= 6'd52);
    accept   = in_valid && !in_hold && len_ok;
    chunk_m  = in_codecoeff & ~({52{1'b1}} >> in_codecoeff_length);
    acc_n    = acc_pop;
    fill_n   = fill_pop;
    if (accept) begin
      acc_n  = acc_pop | ({chunk_m, {(ACC_W-52){1'b0}}} >> fill_pop);
      fill_n = fill_pop + FW'(in_codecoeff_length);
    end else if (state == PAD) begin
      acc_n  = acc_pop | (({ACC_W{1'b1}} >> fill_pop) & ~({ACC_W{1'b1}} >> fill_up));
      fill_n = fill_up;
    end

    word = {stg[0],
            (nload > 3'd1) ? stg[1] : 8'h00,
            (nload > 3'd2) ? stg[2] : 8'h00,
            (nload > 3'd3) ? stg[3] : 8'h00};

    state_n = state;
    case (state)
      RUN:     if (accept && in_tlast) state_n = PAD;
      PAD:     state_n = DRAIN;
      DRAIN:   if (fill == '0) state_n = APPEND_EOI ? EOI : FLUSH;
      EOI:     if (eoi_push) state_n = FLUSH;
      FLUSH:   if (out_valid && !out_hold && out_tlast) state_n = RUN;
      default: state_n = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= RUN;
      acc       <= '0;
      fill      <= '0;
      stg_cnt   <= 4'd0;
      in_hold   <= 1'b1;
      out_valid <= 1'b0;
      out_tlast <= 1'b0;
      out_data  <= 32'h0;
      out_bytes <= 3'd0;
      for (int i = 0; i < STG; i++) stg[i] <= 8'h00;
    end else begin
      state   <= state_n;
      acc     <= acc_n;
      fill    <= fill_n;
      stg_cnt <= stg_cnt_n;
      // Registered copy of the hold condition so it cannot see in_valid.
      in_hold <= (state_n != RUN) || (fill_n > FW'(ACC_W - 52));
      for (int i = 0; i < STG; i++) stg[i] <= stg_n[i];
      if (load) begin
        out_valid <= 1'b1;
        out_data  <= word;
        out_bytes <= nload;
        out_tlast <= (state == FLUSH) && (stg_cnt <= 4'd4);
      end else if (can_out) begin
        out_valid <= 1'b0;
        out_tlast <= 1'b0;
        out_data  <= 32'h0;
        out_bytes <= 3'd0;
      end
    end
  end
endmodule
